// File: rtl/svm_window_ctrl.sv
// svm_window_ctrl
//   Steps one HOG detection window through a single svm_pe. Visits the window's
//   BLK_W x BLK_H blocks in raster order. For each block it puts the feature
//   buffer address and the coefficient ROM address on the outputs, then waits for
//   a fea_ack handshake. It feeds either the bias or the PE feedback into the PE
//   partial-sum input. At the end it latches the final score and compares it with
//   thresh to produce detect.
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   start                begins a window (sampled only in IDLE)
//   win_x, win_y         window origin in blocks (latched when start is accepted)
//   bias, thresh         SVM bias and detect threshold (signed fixed point)
//   busy                 high from the accepted start through the DONE cycle
//   fea_req              feature block request
//   fea_bx, fea_by       requested block coordinates (wrap modulo 2^X_W / 2^Y_W)
//   fea_ack              the buffer presents the block to the PE in this cycle
//   coef_addr            coefficient ROM address, by*BLK_W + bx
//   pe_valid, pe_i_data  PE input strobe and partial-sum input
//   pe_o_data            registered PE partial sum
//   score, detect, done  final result; done is a one-cycle pulse
//
// state  | meaning
// IDLE   | waiting for start
// ADDR   | block address presented; gives the sync ROM one cycle
// REQ    | fea_req high; addresses held until fea_ack
// LAST   | PE register captures the final partial sum
// DONE   | score/detect just latched; done pulse
module svm_window_ctrl #(
  parameter int FEA_I = 4,
  parameter int FEA_F = 28,
  parameter int BLK_W = 7,
  parameter int BLK_H = 15,
  parameter int X_W   = 8,
  parameter int Y_W   = 8,
  parameter int CA_W  = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [X_W-1:0]           win_x,
  input  logic [Y_W-1:0]           win_y,
  input  logic [FEA_I+FEA_F-1:0]   bias,
  input  logic [FEA_I+FEA_F-1:0]   thresh,
  output logic                     busy,
  output logic                     fea_req,
  output logic [X_W-1:0]           fea_bx,
  output logic [Y_W-1:0]           fea_by,
  input  logic                     fea_ack,
  output logic [CA_W-1:0]          coef_addr,
  output logic                     pe_valid,
  output logic [FEA_I+FEA_F-1:0]   pe_i_data,
  input  logic [FEA_I+FEA_F-1:0]   pe_o_data,
  output logic [FEA_I+FEA_F-1:0]   score,
  output logic                     detect,
  output logic                     done
);

  localparam int BX_W = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int BY_W = (BLK_H > 1) ? $clog2(BLK_H) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_LAST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]      state;
  logic [BX_W-1:0] bx, nbx;
  logic [BY_W-1:0] by, nby;
  logic [X_W-1:0]  win_x_q;
  logic [Y_W-1:0]  win_y_q;
  logic            bx_last, by_last, blk_last, first_blk;

  assign bx_last   = (bx == BX_W'(BLK_W - 1));
  assign by_last   = (by == BY_W'(BLK_H - 1));
  assign blk_last  = bx_last && by_last;
  assign first_blk = (bx == '0) && (by == '0);

  // Raster-order successor. After the final block both counters return to 0.
  assign nbx = bx_last ? '0 : bx + BX_W'(1);
  assign nby = bx_last ? (by_last ? '0 : by + BY_W'(1)) : by;

  assign busy      = (state != S_IDLE);
  assign fea_req   = (state == S_REQ);
  assign done      = (state == S_DONE);
  assign pe_valid  = (state == S_REQ) && fea_ack;
  assign pe_i_data = first_blk ? bias : pe_o_data;

  // The addresses are loaded on entry to ADDR. The sync ROM output is then
  // ready by REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      bx        <= '0;
      by        <= '0;
      win_x_q   <= '0;
      win_y_q   <= '0;
      fea_bx    <= '0;
      fea_by    <= '0;
      coef_addr <= '0;
      score     <= '0;
      detect    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ADDR;
            bx        <= '0;
            by        <= '0;
            win_x_q   <= win_x;
            win_y_q   <= win_y;
            fea_bx    <= win_x;
            fea_by    <= win_y;
            coef_addr <= '0;
          end
        end
        S_ADDR: state <= S_REQ;
        S_REQ: begin
          if (fea_ack) begin
            bx <= nbx;
            by <= nby;
            if (blk_last) begin
              state <= S_LAST;
            end else begin
              state     <= S_ADDR;
              fea_bx    <= win_x_q + X_W'(nbx);
              fea_by    <= win_y_q + Y_W'(nby);
              // Raster order makes the ROM address a plain running count.
              coef_addr <= coef_addr + CA_W'(1);
            end
          end
        end
        S_LAST: begin
          state  <= S_DONE;
          score  <= pe_o_data;
          detect <= ($signed(pe_o_data) > $signed(thresh));
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svm_window_ctrl.sv
module tb_svm_window_ctrl;

  localparam int BW = 2;
  localparam int BH = 2;
  localparam int NB = BW * BH;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  win_x, win_y;
  logic [31:0] bias, thresh;
  logic        busy, fea_req, fea_ack, pe_valid, detect, done;
  logic [7:0]  fea_bx, fea_by;
  logic [6:0]  coef_addr;
  logic [31:0] pe_i_data, pe_o_data, score;

  logic [31:0] rom [NB];

  int vectors = 0;
  int miscompares = 0;

  svm_window_ctrl #(
    .FEA_I(4), .FEA_F(28), .BLK_W(BW), .BLK_H(BH), .X_W(8), .Y_W(8), .CA_W(7)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .win_x(win_x), .win_y(win_y),
    .bias(bias), .thresh(thresh), .busy(busy), .fea_req(fea_req),
    .fea_bx(fea_bx), .fea_by(fea_by), .fea_ack(fea_ack), .coef_addr(coef_addr),
    .pe_valid(pe_valid), .pe_i_data(pe_i_data), .pe_o_data(pe_o_data),
    .score(score), .detect(detect), .done(done)
  );

  always #5 clk = ~clk;

  // svm_pe stand-in: the sync ROM product for coef_addr is added to the partial sum.
  always @(posedge clk) begin
    if (pe_valid) pe_o_data <= pe_i_data + rom[coef_addr[1:0]];
  end

  // Runs one full window from the current negedge. Returns at the negedge after done.
  task automatic run_window(input logic [7:0] wx, input logic [7:0] wy, input int maxd,
                            input bit inj_req, input bit inj_done);
    logic [31:0] exp_score;
    bit          exp_det, in_req, got_done;
    int          cyc, waits, blk, pulses, dly;
    logic [7:0]  hx, hy;
    logic [6:0]  hc;
    exp_score = bias;
    for (int k = 0; k < NB; k++) exp_score = exp_score + rom[k];
    exp_det = $signed(exp_score) > $signed(thresh);
    start = 1'b1; win_x = wx; win_y = wy;
    @(negedge clk);
    start = 1'b0; win_x = 8'($urandom); win_y = 8'($urandom);
    cyc = 1; waits = 0; blk = 0; pulses = 0; in_req = 0; got_done = 0; dly = 0;
    hx = '0; hy = '0; hc = '0;
    while (!got_done && cyc < 300) begin
      if (done) begin
        got_done = 1;
      end else begin
        if (fea_req) begin
          if (!in_req) begin
            in_req = 1; hx = fea_bx; hy = fea_by; hc = coef_addr;
            vectors++;
            if (blk >= NB || hx !== 8'(int'(wx) + blk % BW) || hy !== 8'(int'(wy) + blk / BW)
                || hc !== 7'(blk)) begin
              miscompares++;
              $display("FAIL block_addr blk=%0d got bx=%h by=%h ca=%0d want bx=%h by=%h ca=%0d",
                       blk, hx, hy, hc, 8'(int'(wx) + blk % BW), 8'(int'(wy) + blk / BW), blk);
            end
            dly = $urandom_range(0, maxd);
          end else begin
            vectors++;
            if (fea_bx !== hx || fea_by !== hy || coef_addr !== hc) begin
              miscompares++;
              $display("FAIL addr_stable got bx=%h by=%h ca=%0d want bx=%h by=%h ca=%0d",
                       fea_bx, fea_by, coef_addr, hx, hy, hc);
            end
          end
          start = inj_req;
          if (dly == 0) begin
            fea_ack = 1'b1; blk++; in_req = 0;
          end else begin
            fea_ack = 1'b0; dly--; waits++;
          end
        end else begin
          start = 1'b0;
          fea_ack = 1'($urandom_range(0, 1));
        end
        #1;
        if (pe_valid) pulses++;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0; fea_ack = 1'b0;
    vectors++;
    if (!got_done) begin
      miscompares++;
      $display("FAIL done_timeout got no done within %0d cycles want done", cyc);
      return;
    end
    vectors++;
    if (cyc != 2 * NB + 2 + waits) begin
      miscompares++;
      $display("FAIL done_latency got %0d want %0d", cyc, 2 * NB + 2 + waits);
    end
    vectors++;
    if (score !== exp_score || detect !== exp_det) begin
      miscompares++;
      $display("FAIL result got score=%h det=%b want score=%h det=%b", score, detect, exp_score, exp_det);
    end
    vectors++;
    if (pulses != NB || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pulses_busy got pulses=%0d busy=%b want pulses=%0d busy=1", pulses, busy, NB);
    end
    start = inj_done;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || score !== exp_score) begin
      miscompares++;
      $display("FAIL after_done got busy=%b done=%b score=%h want busy=0 done=0 score=%h",
               busy, done, score, exp_score);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (busy !== 1'b0 || fea_req !== 1'b0 || pe_valid !== 1'b0 || done !== 1'b0 ||
        detect !== 1'b0 || score !== 32'h0 || coef_addr !== 7'h0 || fea_bx !== 8'h0 ||
        fea_by !== 8'h0) begin
      miscompares++;
      $display("FAIL %s got busy=%b req=%b pv=%b done=%b det=%b score=%h ca=%h bx=%h by=%h want all 0",
               tag, busy, fea_req, pe_valid, done, detect, score, coef_addr, fea_bx, fea_by);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; fea_ack = 1'b1; win_x = '0; win_y = '0;
    bias = '0; thresh = '0;
    for (int k = 0; k < NB; k++) rom[k] = '0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset_state");
    @(negedge clk);
    rst = 1'b1; fea_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bias = 32'h0800_0000; thresh = 32'h0;
    for (int k = 0; k < NB; k++) rom[k] = '0;
    run_window(8'h00, 8'h00, 0, 0, 0);
  endtask

  task automatic test_negative_and_equal();
    bias = 32'h0800_0000; thresh = 32'h0;
    rom[1] = 32'hF400_0000;
    run_window(8'h03, 8'h05, 0, 0, 0);
    thresh = 32'hFC00_0000;
    run_window(8'h03, 8'h05, 0, 0, 0);
    thresh = 32'hFBFF_FFFF;
    run_window(8'h03, 8'h05, 0, 0, 0);
  endtask

  task automatic test_random_delays();
    for (int i = 0; i < 8; i++) begin
      bias = $urandom; thresh = $urandom;
      for (int k = 0; k < NB; k++) rom[k] = $urandom;
      run_window(8'($urandom), 8'($urandom), 5, 0, 0);
    end
  endtask

  task automatic test_wrap();
    run_window(8'hFF, 8'h10, 2, 0, 0);
    run_window(8'hFF, 8'hFF, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    bias = $urandom; thresh = $urandom;
    for (int k = 0; k < NB; k++) rom[k] = $urandom;
    run_window(8'h20, 8'h30, 3, 1, 1);
    run_window(8'h21, 8'h31, 1, 0, 0);
  endtask

  task automatic test_reset_mid();
    int reqs, cyc;
    bit hit, saw_done;
    bias = 32'h1234_5678; thresh = 32'h0;
    for (int k = 0; k < NB; k++) rom[k] = $urandom;
    start = 1'b1; win_x = 8'h40; win_y = 8'h50;
    @(negedge clk);
    start = 1'b0;
    reqs = 0; hit = 0; cyc = 0;
    while (!hit && cyc < 50) begin
      if (fea_req) begin
        if (reqs == 2) hit = 1;
        else begin fea_ack = 1'b1; reqs++; end
      end else fea_ack = 1'b0;
      if (!hit) begin @(negedge clk); cyc++; end
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL reset_mid_reach got no REQ for block 2 want REQ");
    end
    fea_ack = 1'b1;
    rst = 1'b0;
    #1 check_reset_outputs("reset_mid");
    @(negedge clk);
    rst = 1'b1; fea_ack = 1'b0;
    saw_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("FAIL reset_abort got done/busy after reset want idle");
    end
    run_window(8'h40, 8'h50, 2, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative_and_equal();
    test_random_delays();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
